// File: rtl/mux_arb_pkg.sv
// Shared constants for the N-to-1 streaming multiplexer.
// Latency: none (constants only).
// Backpressure: not applicable.
package mux_arb_pkg;

    // Arbitration mode encoding for the mode input
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Default geometry: the 8-to-1, 4-bit mux this block replaces
    localparam int DEF_N_CH  = 8;
    localparam int DEF_WIDTH = 4;

    // Width of the optional accepted-transfer counter
    localparam int CNT_W = 16;

endpackage

// File: rtl/mux_arb_nto1_rr_pick.sv
// Rotating-priority picker: first asserted request at or after start, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_pick #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    // One extra bit so start + offset cannot overflow before the wrap
    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

    logic [IDX_W:0] cand;

    // Walk start, start+1, ... modulo N and keep the first requesting channel
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, start} + (IDX_W + 1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!grant_valid && req[cand[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 valid/ready stream mux, fixed-select or round-robin, one-entry output register.
// Latency: 1 cycle from input transfer to out_valid; one word per cycle sustained.
// Backpressure: while out_valid & ~out_ready the output is frozen and every in_ready is 0.
// Optional macro MUX_ARB_STATS_EN adds the 16-bit out_count transfer counter port.
module mux_arb_nto1
    import mux_arb_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]        out_count
`endif
);

    localparam logic [SEL_W:0]   N_CH_W  = (SEL_W + 1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic             can_load;
    logic             fix_valid;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             xfer;
    logic [SEL_W-1:0] ptr;

    // Output register can take a word if empty or being drained this cycle
    assign can_load = ~out_valid | out_ready;

    rr_pick #(
        .N     (N_CH),
        .IDX_W (SEL_W)
    ) u_rr_pick (
        .req         (in_valid),
        .start       (ptr),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    // Mode mux: a sel beyond the last channel simply never grants
    always_comb begin
        fix_valid = ({1'b0, sel} < N_CH_W) && in_valid[sel];
        if (mode == MODE_RR) begin
            grant_valid = rr_valid;
            grant_idx   = rr_idx;
        end else begin
            grant_valid = fix_valid;
            grant_idx   = sel;
        end
    end

    // A grant only becomes a transfer when the output can load and reset is low
    assign xfer = grant_valid & can_load & ~rst;

    // Ready is one-hot on the granted channel, zero otherwise
    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register and pointer: load on transfer, otherwise drain when accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant_idx) * WIDTH +: WIDTH];
            out_ch    <= grant_idx;
            ptr       <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_ARB_STATS_EN
    // Accepted-transfer counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= '0;
        end else if (xfer) begin
            out_count <= out_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Randomised and directed checks of mux_arb_nto1 against a queue-free behavioural model.
// Latency: model predicts the registered output one cycle after each transfer.
// Backpressure: exercised by holding out_ready low and by random out_ready.
module tb_mux_arb_nto1;

    localparam int N  = 8;
    localparam int W  = 4;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready;
`ifdef MUX_ARB_STATS_EN
    logic [15:0]     out_count;
`endif

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_ch    = 0;
    int           m_ptr   = 0;
    int           m_count = 0;

    always #5 clk = ~clk;

    mux_arb_nto1 #(.N_CH(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_ARB_STATS_EN
        ,
        .out_count (out_count)
`endif
    );

    // Granted channel by the plain rules, -1 when nobody is granted
    function automatic int model_grant();
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int off = 0; off < N; off++) begin
            if (in_valid[(m_ptr + off) % N]) return (m_ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        g = model_grant();
        if (rst || g < 0 || !(!m_valid || out_ready)) return '0;
        return N'(1) << g;
    endfunction

    // Advance one clock and update the model from the inputs held across the edge
    task automatic step();
        int   g;
        logic cl;
        g  = model_grant();
        cl = !m_valid || out_ready;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0; m_count = 0;
        end else if (g >= 0 && cl) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_ch    = g;
            m_ptr   = (g + 1) % N;
            m_count = (m_count + 1) % 65536;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic set_ch_data_index();
        for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(k);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 8'hFF; out_ready = 1'b1;
        set_ch_data_index();
        #4;
        vectors++;
        if (in_ready !== 8'h00) begin
            errors++; $display("FAIL reset_ready: got %h expected 00", in_ready);
        end
        step();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_ch !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h ch=%0d expected v=0 d=0 ch=0", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 3'd3; in_valid = 8'h08; out_ready = 1'b1;
        set_ch_data_index();
        in_data[3*W +: W] = 4'hA;
        #4;
        vectors++;
        if (in_ready !== 8'h08) begin
            errors++; $display("FAIL fixed_ready: got %h expected 08", in_ready);
        end
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_ch !== 3'd3) begin
            errors++;
            $display("FAIL fixed_out: got v=%b d=%h ch=%0d expected v=1 d=a ch=3", out_valid, out_data, out_ch);
        end
        in_valid = 8'h00;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL fixed_drain: got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_rr_all();
        do_reset();
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        set_ch_data_index();
        for (int i = 0; i < 9; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b1 || int'(out_ch) != i % N || int'(out_data) != i % N) begin
                errors++;
                $display("FAIL rr_all[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%0d",
                         i, out_valid, out_ch, out_data, i % N, i % N);
            end
        end
`ifdef MUX_ARB_STATS_EN
        vectors++;
        if (out_count !== 16'd9) begin
            errors++; $display("FAIL rr_all_count: got %0d expected 9", out_count);
        end
`endif
    endtask

    task automatic test_rr_sparse();
        int exp_ch;
        do_reset();
        mode = 1'b1; in_valid = 8'b1000_0010; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_ch = (i % 2 == 0) ? 1 : 7;
            #4;
            vectors++;
            if (in_ready !== (N'(1) << exp_ch)) begin
                errors++; $display("FAIL rr_sparse_ready[%0d]: got %h expected %h", i, in_ready, N'(1) << exp_ch);
            end
            step();
            vectors++;
            if (int'(out_ch) != exp_ch) begin
                errors++; $display("FAIL rr_sparse[%0d]: got ch=%0d expected %0d", i, out_ch, exp_ch);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]  held_d;
        logic [SW-1:0] held_c;
        mode = 1'b0; sel = 3'd2; in_valid = 8'h04; out_ready = 1'b1;
        for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
        held_d = in_data[2*W +: W];
        held_c = 3'd2;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel = SW'($urandom);
            in_valid = N'($urandom) | 8'h01;
            mode = 1'($urandom);
            #4;
            vectors++;
            if (in_ready !== 8'h00) begin
                errors++; $display("FAIL bp_ready[%0d]: got %h expected 00", i, in_ready);
            end
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_ch !== held_c) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d",
                         i, out_valid, out_data, out_ch, held_d, held_c);
            end
        end
        out_ready = 1'b1;
        in_valid = 8'h00;
        step();
    endtask

    task automatic test_fixed_idle();
        mode = 1'b0; sel = 3'd2; in_valid = 8'h04; out_ready = 1'b1;
        step();
        sel = 3'd5; in_valid = 8'hDF;
        #4;
        vectors++;
        if (in_ready !== 8'h00) begin
            errors++; $display("FAIL idle_ready: got %h expected 00", in_ready);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_drain: got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; in_valid = 8'h30; out_ready = 1'b0;
        set_ch_data_index();
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_ch !== 3'd4) begin
            errors++; $display("FAIL rmid_load: got v=%b ch=%0d expected v=1 ch=4", out_valid, out_ch);
        end
        do_reset();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_ch !== 3'd0) begin
            errors++;
            $display("FAIL rmid_clear: got v=%b d=%h ch=%0d expected v=0 d=0 ch=0", out_valid, out_data, out_ch);
        end
        in_valid = 8'hFF; out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_ch !== 3'd0) begin
            errors++; $display("FAIL rmid_restart: got v=%b ch=%0d expected v=1 ch=0", out_valid, out_ch);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mode      = 1'($urandom);
            sel       = SW'($urandom);
            in_valid  = N'($urandom) & N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
            #4;
            er = model_ready();
            vectors++;
            if (in_ready !== er) begin
                errors++; $display("FAIL rand_ready[%0d]: got %h expected %h", i, in_ready, er);
            end
            step();
            vectors++;
            if (out_valid !== m_valid || (m_valid && (out_data !== m_data || int'(out_ch) != m_ch))) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
                         i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            end
`ifdef MUX_ARB_STATS_EN
            vectors++;
            if (int'(out_count) != m_count) begin
                errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, out_count, m_count);
            end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_sparse();
        test_backpressure();
        test_fixed_idle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
